gnn_io_sequencer: RTL

GNN_IO_SEQUENCER -- requirements
Module: gnn_io_sequencer

---
 rtl/gnn_io_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/gnn_io_sequencer.sv
// Streams 40 feature/weight words into parallel GNN engine inputs, gathers the
// engine's 8 result words under a timeout, then streams them out in order.
module gnn_io_sequencer #(
  parameter int NUM_X   = 16,
  parameter int NUM_W   = 24,
  parameter int NUM_OUT = 8,
  parameter int TIMEOUT = 16,
  parameter int DATA_W  = 5,
  parameter int RES_W   = 21
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_valid,
  input  logic signed [DATA_W-1:0]    s_data,
  output logic                        s_ready,
  output logic [NUM_X*DATA_W-1:0]     feat,
  output logic [NUM_W*DATA_W-1:0]     wgt,
  output logic                        eng_in_ready,
  input  logic [NUM_OUT*RES_W-1:0]    eng_out,
  input  logic [NUM_OUT-1:0]          eng_out_ready,
  output logic                        m_valid,
  output logic signed [RES_W-1:0]     m_data,
  output logic                        m_last,
  input  logic                        m_ready,
  output logic                        busy,
  output logic                        err
);

  localparam int NUM_IN = NUM_X + NUM_W;
  localparam int IDX_W  = $clog2(NUM_IN);
  localparam int OIDX_W = $clog2(NUM_OUT);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [IDX_W-1:0]          r_idx;
  logic [OIDX_W-1:0]         r_oidx;
  logic [NUM_OUT-1:0]        r_mask;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_err;
  logic                      r_eng_in_ready;
  logic [NUM_X*DATA_W-1:0]   r_feat;
  logic [NUM_W*DATA_W-1:0]   r_wgt;
  logic signed [RES_W-1:0]   r_res [NUM_OUT];

  logic                      w_s_fire;
  logic                      w_last_in;
  logic [NUM_OUT-1:0]        w_cap;
  logic [NUM_OUT-1:0]        w_mask_nxt;
  logic                      w_done;
  logic                      w_tmo;
  logic                      w_m_fire;
  logic                      w_out_last;

  assign w_s_fire   = (r_state == LOAD) && s_valid;
  assign w_last_in  = w_s_fire && (r_idx == IDX_W'(NUM_IN - 1));
  // Only first arrival of each word is captured; later ready pulses are ignored.
  assign w_cap      = (r_state == RUN) ? (eng_out_ready & ~r_mask) : '0;
  assign w_mask_nxt = r_mask | w_cap;
  assign w_done     = &w_mask_nxt;
  assign w_tmo      = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_m_fire   = (r_state == DRAIN) && m_ready;
  assign w_out_last = (r_oidx == OIDX_W'(NUM_OUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= LOAD;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LOAD:    if (w_last_in) w_state_nxt = RUN;
      RUN:     if (w_done || w_tmo) w_state_nxt = DRAIN;
      DRAIN:   if (w_m_fire && w_out_last) w_state_nxt = LOAD;
      default: w_state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx          <= '0;
      r_oidx         <= '0;
      r_mask         <= '0;
      r_cnt          <= '0;
      r_err          <= 1'b0;
      r_eng_in_ready <= 1'b0;
    end else begin
      r_eng_in_ready <= (w_state_nxt == RUN);
      case (r_state)
        LOAD: begin
          if (w_last_in) begin
            r_idx  <= '0;
            r_mask <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
          end else if (w_s_fire) begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        RUN: begin
          r_mask <= w_mask_nxt;
          r_cnt  <= r_cnt + CNT_W'(1);
          // A capture landing on the timeout cycle can still rescue the run.
          if (w_tmo && !w_done) r_err <= 1'b1;
        end
        DRAIN: begin
          if (w_m_fire) begin
            if (w_out_last) begin
              r_oidx <= '0;
              r_idx  <= '0;
            end else begin
              r_oidx <= r_oidx + OIDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_feat <= '0;
      r_wgt  <= '0;
    end else begin
      for (int k = 0; k < NUM_X; k++)
        if (w_s_fire && (r_idx == IDX_W'(k)))
          r_feat[k*DATA_W +: DATA_W] <= s_data;
      for (int k = 0; k < NUM_W; k++)
        if (w_s_fire && (r_idx == IDX_W'(NUM_X + k)))
          r_wgt[k*DATA_W +: DATA_W] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NUM_OUT; j++) r_res[j] <= '0;
    end else begin
      for (int j = 0; j < NUM_OUT; j++) begin
        if (w_last_in)     r_res[j] <= '0;
        else if (w_cap[j]) r_res[j] <= eng_out[j*RES_W +: RES_W];
      end
    end
  end

  assign s_ready      = (r_state == LOAD);
  assign eng_in_ready = r_eng_in_ready;
  assign m_valid      = (r_state == DRAIN);
  assign m_data       = r_res[r_oidx];
  assign m_last       = m_valid && w_out_last;
  assign busy         = (r_state == RUN) || (r_state == DRAIN);
  assign err          = r_err;
  assign feat         = r_feat;
  assign wgt          = r_wgt;

endmodule
